// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// bit-counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1 and never collapse to zero bits.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder made of two half-adder stages whose carries are ORed.
// Purely combinational; the serial adder feeds it one operand bit per cycle.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_carry_s;

    // First stage adds the operand bits, second stage folds in the carry.
    assign ha0_sum_s   = x ^ y;
    assign ha0_carry_s = x & y;
    assign s           = ha0_sum_s ^ cin;
    assign ha1_carry_s = ha0_sum_s & cin;
    assign cout        = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with valid/ready on both sides.
// Optional subtract mode is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             out_valid_r;

    logic             sub_s;
    logic             accept_s;
    logic             last_s;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH:0]   sum_ext_s;
    logic [WIDTH-1:0] b_load_s;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
    assign b_load_s  = sub_s ? ~b : b;
    assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign last_s    = (cnt_r == CW'(WIDTH - 1));
    assign sum_ext_s = {fa_sum_s, sum_r};

    full_adder_cell u_fa (
        .x    (a_sr_r[0]),
        .y    (b_sr_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Control FSM together with the operand/sum shift registers and carry flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b_load_s;
                        carry_r <= sub_s;
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // New sum bit enters at the MSB so the LSB lands at bit 0 last.
                    sum_r   <= sum_ext_s[WIDTH:1];
                    a_sr_r  <= a_sr_r >> 1;
                    b_sr_r  <= b_sr_r >> 1;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        carry_out_r <= fa_cout_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r     <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            a_sr_r  <= a;
                            b_sr_r  <= b_load_s;
                            carry_r <= sub_s;
                            cnt_r   <= '0;
                            state_r <= RUN;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed and random transactions are
// checked against an arithmetic reference model by an independent monitor.
module tb_serial_adder;

    localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    typedef struct {
        logic [WIDTH:0] res;
        int             acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub_r = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    exp_t             q[$];
    exp_t             mon_e;
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    bit               rand_phase = 1'b0;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic [WIDTH:0]   prev_res = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: {carry_out,sum} = a+b, or for subtract (a-b mod 2^W, no-borrow flag).
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic sv);
        int ai;
        int bi;
        int r;
        ai = int'(av);
        bi = int'(bv);
        if (HAS_SUB && sv) begin
            r = ai - bi;
            return {(ai >= bi), r[WIDTH-1:0]};
        end else begin
            r = ai + bi;
            return r[WIDTH:0];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands (caller is just after a rising edge); push expectation on accept.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
        exp_t e;
        bit   ok;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        sub_r    = sv;
        ok       = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok    = 1'b1;
                e.res = model(av, bv, sv);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
        if (!ok) flag("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            flag("drain_timeout");
            q.delete();
        end
        step();
    endtask

    // Monitor: latency, result, hold stability and in_ready blocking while DONE.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) flag("spurious_out_valid");
                else check("latency", cyc - q[0].acc, WIDTH);
            end
            if (out_valid && prev_valid && !prev_ready)
                check("hold_stable", {carry_out, sum}, prev_res);
            if (out_valid && !out_ready)
                check("in_ready_done_blocked", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    flag("unexpected_result");
                end else begin
                    mon_e = q.pop_front();
                    check("result", {carry_out, sum}, mon_e.res);
                end
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
            prev_res   <= {carry_out, sum};
        end
    end

    // Random backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_phase) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        // Reset held with garbage on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            @(negedge clk);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_sum", sum, 8'h00);
            check("rst_carry", carry_out, 1'b0);
            check("rst_in_ready", in_ready, 1'b1);
        end
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) step();
        check("post_rst_out_valid", out_valid, 1'b0);

        // Basic add and carry ripple.
        out_ready = 1'b1;
        send(8'h35, 8'h4A, 1'b0);
        @(negedge clk);
        check("in_ready_run", in_ready, 1'b0);
        drain();
        send(8'hFF, 8'h01, 1'b0);
        drain();
        send(8'hFF, 8'hFF, 1'b0);
        drain();

        // Backpressure, then back-to-back accept on the releasing edge.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        for (int n = 0; n < 30 && !out_valid; n++) step();
        if (!out_valid) flag("backpressure_no_result");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            step();
        end
        out_ready = 1'b1;
        send(8'h80, 8'h80, 1'b0);
        drain();

        // Reset in the middle of a RUN.
        send(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 8'h00);
        check("midrst_carry", carry_out, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        send(8'h01, 8'h02, 1'b0);
        drain();

`ifdef SERIAL_ADDER_SUB_EN
        send(8'h10, 8'h01, 1'b1);
        drain();
        send(8'h01, 8'h02, 1'b1);
        drain();
        send(8'h10, 8'h01, 1'b0);
        drain();
`endif

        // Random transactions with random backpressure.
        rand_phase = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send(WIDTH'($urandom), WIDTH'($urandom), HAS_SUB & 1'($urandom));
        end
        rand_phase = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that accepts two operands over a valid/ready handshake.
- Adds one bit per clock, LSB first, through a full-adder cell built from two half-adder stages, with the carry held in a flop between cycles.
- Returns the N-bit sum and carry-out over a second valid/ready handshake.
- Sits downstream of the combinational adder primitives as the area-minimal multi-bit arithmetic stage.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b are presented
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- out_valid  output  1  sum/carry_out hold a completed result
- out_ready  input  1  downstream consumes the result
- sum  output  WIDTH  result bits; defined only while out_valid=1
- carry_out  output  1  final carry; defined only while out_valid=1

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous): state=IDLE, bit counter=0, carry flop=0, operand shift registers=0, sum=0, carry_out=0, out_valid=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready), combinational. It is therefore 1 during reset.
- FSM states and transitions:
  - IDLE: on in_valid & in_ready, load a and b into shift registers, carry=0, cnt=0, go to RUN.
  - RUN: each edge, full-adder cell takes (a_sr[0], b_sr[0], carry). The result bit shifts into sum MSB-side (right shift). a_sr/b_sr shift right, carry updates, cnt increments. On the edge where cnt==WIDTH-1, carry_out takes the final carry and state goes to DONE.
  - DONE: out_valid=1. sum and carry_out are held stable while out_ready=0, and in_valid is ignored.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: new operands are loaded on the same edge and state goes directly to RUN (back-to-back, no IDLE bubble).
- Latency: out_valid rises exactly WIDTH edges after the accepting edge. Throughput: one result per WIDTH+1 cycles with continuous out_ready.
- Arithmetic: {carry_out,sum} = a + b, modulo 2^(WIDTH+1). No saturation.
- Counter width: max(1, $clog2(WIDTH)). WIDTH=1 yields a single RUN cycle.
- sum port during RUN shows partial shift contents; this is not checked.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted with no output. Registers return to reset values, and the first post-reset operation must be correct.
- No other inputs affect state outside the handshake rules above.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled on accept.
  - sub=1: b is loaded inverted and the carry flop initialises to 1, so sum = a - b mod 2^WIDTH and carry_out = 1 means no borrow (a >= b unsigned).
  - sub=0: identical to add.
- Undefined: port sub is absent and the block always adds.

Decomposition:
- Package serial_adder_pkg:
  - FSM state enum {IDLE, RUN, DONE}, 2 bits.
  - Function for the counter width, max(1, clog2(WIDTH)).
- Sub-module full_adder_cell: inputs x, y, cin; outputs s, cout; built from two half-adder stages plus an OR of their carries; purely combinational.
- Top-level serial_adder holds the FSM, counter, shift registers and carry flop.

Test Plan (WIDTH=8):
- Reset: hold rst_n low 3 cycles with random in_valid/a/b -> out_valid=0, sum=0x00, carry_out=0, in_ready=1; release, no spurious out_valid.
- Basic add: a=0x35, b=0x4A accepted at edge k, out_ready=1 -> out_valid first high after edge k+8, sum=0x7F, carry_out=0; in_ready=0 during RUN.
- Carry ripple: a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0xFF, b=0xFF -> sum=0xFE, carry_out=1.
- Backpressure and back-to-back:
  - Result pending with out_ready=0 for 5 cycles -> sum/carry_out stable, in_ready=0, in_valid pulses ignored.
  - Then out_ready=1 with in_valid=1, a=0x80, b=0x80 -> accepted same edge; next result sum=0x00, carry_out=1 exactly 8 edges later.
- Reset mid-operation: assert rst_n low at RUN cycle 4 of a=0x12, b=0x34 -> outputs return to reset values immediately; after release, a=0x01, b=0x02 -> sum=0x03, carry_out=0.
- SERIAL_ADDER_SUB_EN build:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, carry_out=1.
  - sub=1, a=0x01, b=0x02 -> sum=0xFF, carry_out=0.
  - sub=0, a=0x10, b=0x01 -> sum=0x11, carry_out=0.
